// File: rtl/sd_stream_prefetch_pkg.sv
// Shared constants, FSM encoding and clog2 helper for the SD stream prefetcher.
package sd_stream_prefetch_pkg;
  localparam int SD_SECTOR_BYTES = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/sd_stream_fifo.sv
// Show-ahead synchronous FIFO: inferred RAM feeding a registered output word.
module sd_stream_fifo
  import sd_stream_prefetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk0,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      mcnt;
  logic             vld, wr_ok, pop, load;

  // level includes the word parked in the output register
  assign level = mcnt + (AW+1)'(vld);
  assign full  = level == (AW+1)'(DEPTH);
  assign empty = !vld;
  assign wr_ok = wr && !full;
  assign pop   = rd && vld;
  assign load  = (mcnt != '0) && (!vld || pop);

  always_ff @(posedge clk0)
    if (wr_ok) mem[wptr] <= wdata;

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      mcnt  <= '0;
      vld   <= 1'b0;
      rdata <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (load) begin
        rdata <= mem[rptr];
        rptr  <= rptr + AW'(1);
      end
      if (load)     vld <= 1'b1;
      else if (pop) vld <= 1'b0;
      mcnt <= mcnt + (AW+1)'(wr_ok) - (AW+1)'(load);
    end
  end
endmodule

// File: rtl/sd_stream_prefetch.sv
// Sector-prefetching byte-to-word stream buffer between SD/FAT32 file reader and H.264 consumer.
// Optional byte_cnt output enabled by defining SD_STREAM_BYTE_CNT_EN.
module sd_stream_prefetch
  import sd_stream_prefetch_pkg::*;
#(
  parameter int OUT_WIDTH     = 32,
  parameter int DEPTH_SECTORS = 2,
  parameter int BIG_ENDIAN    = 1,
  localparam int BPW          = OUT_WIDTH / 8,
  localparam int SECTOR_WORDS = SD_SECTOR_BYTES / BPW,
  localparam int WORDS        = DEPTH_SECTORS * SECTOR_WORDS,
  localparam int LW           = clog2(WORDS) + 1
) (
  input  logic                 clk0,
  input  logic                 rst_n,
  input  logic                 start_i,
  output logic                 file_read_req,
  input  logic [7:0]           file_data,
  input  logic                 file_data_valid,
  input  logic                 file_reach_end,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [LW-1:0]        level,
  output logic                 eos,
`ifdef SD_STREAM_BYTE_CNT_EN
  output logic [31:0]          byte_cnt,
`endif
  output logic                 err
);
  localparam logic [8:0] POS_MASK = 9'(BPW - 1);

  state_e               state;
  logic [8:0]           bcnt;
  logic [OUT_WIDTH-1:0] sr, sr_nxt, b_ext, wdata_q;
  logic                 wr_q, full, empty, accept, last_in_word, pk_empty, room;

  assign accept       = (state == RECV) && file_data_valid;
  assign last_in_word = (bcnt & POS_MASK) == POS_MASK;
  assign pk_empty     = ((bcnt & POS_MASK) == 9'd0) && !wr_q;
  // the word still waiting to be written counts against free space
  assign room         = (int'(level) + int'(wr_q)) <= (WORDS - SECTOR_WORDS);
  assign dout_valid   = !empty;

  always_comb begin
    b_ext = OUT_WIDTH'(file_data);
    if (BIG_ENDIAN != 0) sr_nxt = (sr << 8) | b_ext;
    else                 sr_nxt = (sr >> 8) | (b_ext << (OUT_WIDTH - 8));
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bcnt          <= '0;
      file_read_req <= 1'b0;
    end else begin
      file_read_req <= 1'b0;
      case (state)
        IDLE:
          if (file_reach_end) state <= DONE;
          else if (start_i && room) begin
            state         <= REQ;
            file_read_req <= 1'b1;
          end
        REQ: state <= RECV;
        RECV:
          if (file_data_valid) begin
            bcnt <= bcnt + 9'd1;
            if (bcnt == 9'd511) state <= IDLE;
          end
        default: state <= DONE;
      endcase
    end
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err     <= 1'b0;
      eos     <= 1'b0;
    end else begin
      wr_q <= accept && last_in_word;
      if (accept) begin
        if (last_in_word) begin
          wdata_q <= sr_nxt;
          sr      <= '0;
        end else begin
          sr <= sr_nxt;
        end
      end
      if ((file_data_valid && state != RECV) || (wr_q && full)) err <= 1'b1;
      eos <= (state == DONE) && pk_empty && (level == '0);
    end
  end

`ifdef SD_STREAM_BYTE_CNT_EN
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n)      byte_cnt <= '0;
    else if (accept) byte_cnt <= byte_cnt + 32'd1;
  end
`endif

  sd_stream_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (WORDS)
  ) u_fifo (
    .clk0  (clk0),
    .rst_n (rst_n),
    .wr    (wr_q),
    .wdata (wdata_q),
    .rd    (dout_ready),
    .rdata (dout),
    .empty (empty),
    .full  (full),
    .level (level)
  );
endmodule
